// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle product at accept.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [2:0]       f3_q;
    logic             sa_q, sb_q, spec_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             a_signed, b_signed, in_sa, in_sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf, special, fast_mul;

    always_comb begin
        a_signed = (FUNCT3 == 3'd1) || (FUNCT3 == 3'd2) || (FUNCT3 == 3'd4) || (FUNCT3 == 3'd6);
        b_signed = (FUNCT3 == 3'd1) || (FUNCT3 == 3'd4) || (FUNCT3 == 3'd6);
        in_sa    = a_signed & OP_A[WIDTH-1];
        in_sb    = b_signed & OP_B[WIDTH-1];
        mag_a    = in_sa ? -OP_A : OP_A;
        mag_b    = in_sb ? -OP_B : OP_B;
        div_zero = FUNCT3[2] && (OP_B == '0);
        div_ovf  = FUNCT3[2] && !FUNCT3[0] && (OP_A == MIN_NEG) && (OP_B == '1);
        special  = div_zero | div_ovf;
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = !FUNCT3[2];
`else
        fast_mul = 1'b0;
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // One shift-add multiply step: product low half shifts in from the top.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    // One restoring divide step: partial remainder never exceeds divisor after subtract.
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    assign rem_shift = {acc_hi, a_q[WIDTH-1]};
    assign div_ge    = rem_shift >= {1'b0, b_q};
    assign div_diff  = rem_shift[WIDTH-1:0] - b_q;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quot_fix = (spec_q || !(sa_q ^ sb_q)) ? acc_lo : -acc_lo;
        rem_fix  = (spec_q || !sa_q) ? acc_hi : -acc_hi;
        case (f3_q)
            3'd0:       fix_result = prod_fix[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:       fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5: fix_result = quot_fix;
            default:    fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (FLUSH) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (START) state_nxt = (special || fast_mul) ? S_FIX : S_CALC;
                S_CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        BUSY = ((state == S_IDLE) && START && !FLUSH) || (state == S_CALC) || (state == S_FIX);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            spec_q   <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (FLUSH) begin
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        f3_q   <= FUNCT3;
                        sa_q   <= in_sa;
                        sb_q   <= in_sb;
                        spec_q <= special;
                        cnt    <= '0;
                        a_q    <= mag_a;
                        b_q    <= mag_b;
                        if (div_zero) begin
                            acc_hi <= OP_A;
                            acc_lo <= '1;
                        end else if (div_ovf) begin
                            acc_hi <= '0;
                            acc_lo <= OP_A;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (fast_mul) begin
                            {acc_hi, acc_lo} <= fast_prod;
`endif
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= '0;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (f3_q[2]) begin
                        acc_hi <= div_ge ? div_diff : rem_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        a_q    <= {a_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                end
                default: done_q <= 1'b0;
            endcase
        end
    end

    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] OP_A, OP_B;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .OP_A(OP_A), .OP_B(OP_B), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f3)
            3'd0: begin p = ua * ub;          r = p[31:0];  end
            3'd1: begin p = sa * sb;          r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub;          r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    always @(negedge CLK) begin
        logic [31:0] e;
        if (!RESET && DONE) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", {31'b0, DONE}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result", RESULT, e);
            end
        end
    end

    // Entered at a negedge with START high in IDLE; next posedge is the accept edge.
    task automatic wait_done(input int lat);
        int got_k;
        int busy_low;
        got_k    = lat + 5;
        busy_low = 0;
        @(posedge CLK);
        @(negedge CLK);
        if (!BUSY) busy_low++;
        OP_A = $urandom;
        OP_B = $urandom;
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) begin
                got_k = k;
                break;
            end
            if (!BUSY) busy_low++;
        end
        check_eq("busy_during_op", busy_low, 0);
        check_eq("latency", got_k, lat);
        check_eq("busy_in_done", {31'b0, BUSY}, 32'd0);
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        FUNCT3 = f3;
        OP_A   = a;
        OP_B   = b;
        START  = 1'b1;
        exp_q.push_back(exp);
        wait_done(ref_lat(f3, a, b));
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        FUNCT3 = 3'd0; OP_A = '0; OP_B = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("reset_done", {31'b0, DONE}, 32'd0);
        check_eq("reset_result", RESULT, 32'd0);
        check_eq("reset_busy", {31'b0, BUSY}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        do_op(3'd5, 32'd100,        32'd7,         32'h0000_000E);
        do_op(3'd7, 32'd100,        32'd7,         32'h0000_0002);
        do_op(3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
        do_op(3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678);
        do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Squash after 10 CALC cycles, then a fresh op right behind it.
        FUNCT3 = 3'd5; OP_A = 32'd5000; OP_B = 32'd3; START = 1'b1;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b0;
        check_eq("busy_after_flush", {31'b0, BUSY}, 32'd0);
        check_eq("done_after_flush", {31'b0, DONE}, 32'd0);
        do_op(3'd5, 32'd1000, 32'd10, 32'd100);

        // FLUSH coincident with START in IDLE must not accept.
        FUNCT3 = 3'd0; OP_A = 32'd3; OP_B = 32'd4; START = 1'b1; FLUSH = 1'b1;
        check_eq("busy_start_flush", {31'b0, BUSY}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        check_eq("idle_after_start_flush", {31'b0, BUSY}, 32'd0);

        // Reset during CALC iteration 5.
        FUNCT3 = 3'd4; OP_A = 32'd1000; OP_B = 32'd3; START = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1; START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("midop_reset_done", {31'b0, DONE}, 32'd0);
        check_eq("midop_reset_result", RESULT, 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("idle_after_reset", {31'b0, BUSY}, 32'd0);

        // START held through DONE and beyond: one DONE, then a second accept.
        FUNCT3 = 3'd5; OP_A = 32'd100; OP_B = 32'd7; START = 1'b1;
        exp_q.push_back(32'd14);
        wait_done(33);
        @(posedge CLK);
        @(negedge CLK);
        check_eq("single_done_pulse", {31'b0, DONE}, 32'd0);
        check_eq("second_accept_pending", {31'b0, BUSY}, 32'd1);
        OP_A = 32'd100; OP_B = 32'd7;
        exp_q.push_back(32'd14);
        wait_done(33);
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : $urandom;
            do_op(f3, a, b, ref_op(f3, a, b));
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
